// File: rtl/mem_pkg.sv
// Shared constants for mem_responder: MMIO map, register offsets and timer reset values.
package mem_pkg;

  localparam logic [31:0] MmioBaseDefault = 32'h8000_0000;

  localparam logic [11:0] OffTohost     = 12'h000;
  localparam logic [11:0] OffMtimeLo    = 12'h004;
  localparam logic [11:0] OffMtimeHi    = 12'h008;
  localparam logic [11:0] OffMtimecmpLo = 12'h00C;
  localparam logic [11:0] OffMtimecmpHi = 12'h010;

  localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

  // MMIO registers are word-granular; the byte lane bits never select a register.
  function automatic logic off_hit(input logic [11:0] off, input logic [11:0] reg_off);
    return (off >> 2) == (reg_off >> 2);
  endfunction

endpackage

// File: rtl/mem_mtimer.sv
// Machine timer: free-running 64-bit mtime, mtimecmp, HI snapshot and registered timer_irq.
module mem_mtimer
  import mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] off_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] wdata_i,
  output logic        hit_o,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] snap_q, snap_d;
  logic        irq_q, irq_d;

  always_comb begin
    hit_o = off_hit(off_i, OffMtimeLo) | off_hit(off_i, OffMtimeHi) |
            off_hit(off_i, OffMtimecmpLo) | off_hit(off_i, OffMtimecmpHi);

    rdata_o = '0;
    if (off_hit(off_i, OffMtimeLo))         rdata_o = mtime_q[31:0];
    else if (off_hit(off_i, OffMtimeHi))    rdata_o = snap_q;
    else if (off_hit(off_i, OffMtimecmpLo)) rdata_o = cmp_q[31:0];
    else if (off_hit(off_i, OffMtimecmpHi)) rdata_o = cmp_q[63:32];

    // A write to either mtime half replaces this cycle's increment.
    mtime_d = mtime_q + 64'd1;
    cmp_d   = cmp_q;
    snap_d  = snap_q;
    if (wr_i && off_hit(off_i, OffMtimeLo))    mtime_d = {mtime_q[63:32], wdata_i};
    if (wr_i && off_hit(off_i, OffMtimeHi))    mtime_d = {wdata_i, mtime_q[31:0]};
    if (wr_i && off_hit(off_i, OffMtimecmpLo)) cmp_d[31:0] = wdata_i;
    if (wr_i && off_hit(off_i, OffMtimecmpHi)) cmp_d[63:32] = wdata_i;
    if (rd_i && off_hit(off_i, OffMtimeLo))    snap_d = mtime_q[63:32];

    irq_d = (mtime_q >= cmp_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q <= '0;
      cmp_q   <= MtimecmpReset;
      snap_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      snap_q  <= snap_d;
      irq_q   <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/mem_responder.sv
// Single-port RAM plus MMIO responder with two-stage read pipeline.
// Optional machine timer enabled by defining MMIO_TIMER_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = MmioBaseDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_r_enable,
  input  logic        mem_w_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        bus_err,
  output logic [31:0] tohost,
  output logic        tohost_valid,
  output logic        timer_irq
);

  localparam int unsigned AddrW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RamBytes = 32'(DEPTH_WORDS * 4);

  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] ram_rdata_q;

  logic             in_ram, in_mmio, tohost_hit, tmr_hit, mapped;
  logic [11:0]      mmio_off;
  logic [AddrW-1:0] word_idx;
  logic [31:0]      tmr_rdata, mmio_rdata;

  // Stage 1 holds the accepted request, stage 2 drives the outputs.
  logic        rd_pend_q, rd_pend_d;
  logic        rd_ram_q, rd_ram_d;
  logic        rd_err_q, rd_err_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] tohost_q, tohost_d;
  logic        tohost_valid_q, tohost_valid_d;

  always_comb begin
    in_ram     = (mem_addr < RamBytes);
    in_mmio    = (mem_addr[31:12] == MMIO_BASE[31:12]);
    mmio_off   = mem_addr[11:0];
    word_idx   = mem_addr[AddrW+1:2];
    tohost_hit = in_mmio & off_hit(mmio_off, OffTohost);
    mapped     = in_ram | tohost_hit | tmr_hit;
    mmio_rdata = tohost_hit ? tohost_q : tmr_rdata;
  end

`ifdef MMIO_TIMER_EN
  logic tmr_sel;

  mem_mtimer u_mtimer (
    .clk_i   (clk),
    .rst_i   (reset),
    .off_i   (mmio_off),
    .rd_i    (mem_r_enable & in_mmio),
    .wr_i    (mem_w_enable & in_mmio),
    .wdata_i (mem_wdata),
    .hit_o   (tmr_sel),
    .rdata_o (tmr_rdata),
    .irq_o   (timer_irq)
  );

  assign tmr_hit = in_mmio & tmr_sel;
`else
  assign tmr_hit   = 1'b0;
  assign tmr_rdata = '0;
  assign timer_irq = 1'b0;
`endif

  // RAM is deliberately left out of reset; the read captures pre-write content.
  always_ff @(posedge clk) begin
    if (mem_w_enable && in_ram) ram[word_idx] <= mem_wdata;
    if (mem_r_enable && in_ram) ram_rdata_q <= ram[word_idx];
  end

  always_comb begin
    rd_pend_d    = mem_r_enable;
    rd_ram_d     = in_ram;
    rd_err_d     = mem_r_enable & ~mapped;
    mmio_rdata_d = mem_r_enable ? mmio_rdata : mmio_rdata_q;

    rdata_d = rdata_q;
    if (rd_pend_q) begin
      if (rd_err_q)      rdata_d = '0;
      else if (rd_ram_q) rdata_d = ram_rdata_q;
      else               rdata_d = mmio_rdata_q;
    end
    rvalid_d  = rd_pend_q;
    bus_err_d = (rd_pend_q & rd_err_q) | (mem_w_enable & ~mapped);

    tohost_d       = tohost_q;
    tohost_valid_d = 1'b0;
    if (mem_w_enable && tohost_hit) begin
      tohost_d       = mem_wdata;
      tohost_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q      <= 1'b0;
      rd_ram_q       <= 1'b0;
      rd_err_q       <= 1'b0;
      mmio_rdata_q   <= '0;
      rdata_q        <= '0;
      rvalid_q       <= 1'b0;
      bus_err_q      <= 1'b0;
      tohost_q       <= '0;
      tohost_valid_q <= 1'b0;
    end else begin
      rd_pend_q      <= rd_pend_d;
      rd_ram_q       <= rd_ram_d;
      rd_err_q       <= rd_err_d;
      mmio_rdata_q   <= mmio_rdata_d;
      rdata_q        <= rdata_d;
      rvalid_q       <= rvalid_d;
      bus_err_q      <= bus_err_d;
      tohost_q       <= tohost_d;
      tohost_valid_q <= tohost_valid_d;
    end
  end

  assign mem_rdata    = rdata_q;
  assign mem_rvalid   = rvalid_q;
  assign bus_err      = bus_err_q;
  assign tohost       = tohost_q;
  assign tohost_valid = tohost_valid_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// checked against a behavioural memory/MMIO model.
module tb_mem_responder;

`ifdef MMIO_TIMER_EN
  localparam bit TimerEn = 1'b1;
`else
  localparam bit TimerEn = 1'b0;
`endif
  localparam logic [31:0] MmioBase = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_r_enable, mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rvalid, bus_err;
  logic [31:0] tohost;
  logic        tohost_valid, timer_irq;

  mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_r_enable (mem_r_enable),
    .mem_w_enable (mem_w_enable),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .bus_err      (bus_err),
    .tohost       (tohost),
    .tohost_valid (tohost_valid),
    .timer_irq    (timer_irq)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [31:0] m_ram [4096];
  logic [31:0] m_tohost, m_snap;
  logic [63:0] m_mtime, m_cmp;
  bit          p_valid, p_err;
  logic [31:0] p_data;
  logic [31:0] e_rdata;
  bit          e_rvalid, e_err, e_tv, e_irq;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 = RAM, 1 = TOHOST, 2 = timer register, 3 = unmapped
  function automatic int region(input logic [31:0] a);
    int ow;
    if (a < 32'd16384) return 0;
    if ((a >> 12) == (MmioBase >> 12)) begin
      ow = int'((a & 32'hFFF) >> 2);
      if (ow == 0) return 1;
      if (TimerEn && ow >= 1 && ow <= 4) return 2;
    end
    return 3;
  endfunction

  task automatic model_edge(input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input bit rst);
    int rg, ow;
    logic [31:0] rv;
    logic [63:0] mt_next;
    if (rst) begin
      p_valid = 0; p_err = 0; e_rvalid = 0; e_err = 0; e_tv = 0; e_irq = 0;
      e_rdata = 0; m_tohost = 0; m_snap = 0; m_mtime = 0; m_cmp = '1;
      return;
    end
    rg = region(a);
    ow = int'((a & 32'hFFF) >> 2);
    e_rvalid = p_valid;
    if (p_valid) e_rdata = p_err ? 32'h0 : p_data;
    e_err = p_valid && p_err;
    e_tv  = 0;
    e_irq = TimerEn && (m_mtime >= m_cmp);
    rv = 0;
    if (rg == 0) rv = m_ram[a[13:2]];
    else if (rg == 1) rv = m_tohost;
    else if (rg == 2) begin
      if (ow == 1) rv = m_mtime[31:0];
      else if (ow == 2) rv = m_snap;
      else if (ow == 3) rv = m_cmp[31:0];
      else rv = m_cmp[63:32];
    end
    p_valid = r;
    p_err   = (rg == 3);
    p_data  = rv;
    if (r && rg == 2 && ow == 1) m_snap = m_mtime[63:32];
    mt_next = m_mtime + 64'd1;
    if (w) begin
      if (rg == 0) m_ram[a[13:2]] = d;
      else if (rg == 1) begin
        m_tohost = d;
        e_tv = 1;
      end else if (rg == 2) begin
        if (ow == 1) mt_next = {m_mtime[63:32], d};
        else if (ow == 2) mt_next = {d, m_mtime[31:0]};
        else if (ow == 3) m_cmp[31:0] = d;
        else m_cmp[63:32] = d;
      end else e_err = 1;
    end
    m_mtime = mt_next;
  endtask

  task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit rst);
    @(negedge clk);
    reset = rst; mem_r_enable = r; mem_w_enable = w; mem_addr = a; mem_wdata = d;
    @(posedge clk);
    model_edge(r, w, a, d, rst);
    #1;
    check_eq("rvalid", {63'd0, mem_rvalid}, {63'd0, e_rvalid});
    check_eq("rdata", {32'd0, mem_rdata}, {32'd0, e_rdata});
    check_eq("bus_err", {63'd0, bus_err}, {63'd0, e_err});
    check_eq("tohost", {32'd0, tohost}, {32'd0, m_tohost});
    check_eq("tohost_valid", {63'd0, tohost_valid}, {63'd0, e_tv});
    check_eq("timer_irq", {63'd0, timer_irq}, {63'd0, e_irq});
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    logic [31:0] a;
    bit r, w;
    int sel;
    reset = 1; mem_r_enable = 0; mem_w_enable = 0; mem_addr = 0; mem_wdata = 0;
    step(0, 0, 32'h0, 32'h0, 1);
    step(0, 0, 32'h0, 32'h0, 1);
    check_eq("reset_rdata", {32'd0, mem_rdata}, 64'd0);
    check_eq("reset_irq", {63'd0, timer_irq}, 64'd0);

    for (int i = 0; i < 64; i++) step(0, 1, 32'(i * 4), $urandom, 0);
    step(0, 1, 32'h0000_3FFC, 32'hA5A5_0001, 0);

    // Write then unaligned read of the same word
    step(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    step(1, 0, 32'h13, 32'h0, 0);
    idle();
    check_eq("deadbeef_rdata", {32'd0, mem_rdata}, 64'hDEAD_BEEF);
    check_eq("deadbeef_rvalid", {63'd0, mem_rvalid}, 64'd1);
    idle();
    check_eq("rvalid_one_cycle", {63'd0, mem_rvalid}, 64'd0);

    // Read-before-write
    step(0, 1, 32'h20, 32'h1, 0);
    step(1, 1, 32'h20, 32'h2, 0);
    step(1, 0, 32'h20, 32'h0, 0);
    check_eq("rbw_old", {32'd0, mem_rdata}, 64'h1);
    idle();
    check_eq("rbw_new", {32'd0, mem_rdata}, 64'h2);
    step(1, 0, 32'h0000_3FFC, 32'h0, 0);
    idle();
    check_eq("ram_top_word", {32'd0, mem_rdata}, 64'hA5A5_0001);

    // Unmapped accesses
    step(1, 0, 32'h4000_0000, 32'h0, 0);
    idle();
    check_eq("unmapped_rd_err", {63'd0, bus_err}, 64'd1);
    check_eq("unmapped_rd_data", {32'd0, mem_rdata}, 64'd0);
    step(0, 1, 32'h4000_0000, 32'h55, 0);
    check_eq("unmapped_wr_err", {63'd0, bus_err}, 64'd1);
    step(1, 0, 32'h0, 32'h0, 0);
    idle();

    // TOHOST
    step(0, 1, MmioBase, 32'h1, 0);
    check_eq("tohost_val", {32'd0, tohost}, 64'h1);
    check_eq("tohost_pulse", {63'd0, tohost_valid}, 64'd1);
    idle();
    check_eq("tohost_pulse_end", {63'd0, tohost_valid}, 64'd0);

`ifdef MMIO_TIMER_EN
    step(0, 1, MmioBase | 32'hC, 32'h0, 0);
    step(0, 1, MmioBase | 32'h10, 32'h0, 0);
    step(0, 1, MmioBase | 32'h8, 32'hFFFF_FFFF, 0);
    step(0, 1, MmioBase | 32'h4, 32'hFFFF_FFFE, 0);
    idle(); idle(); idle();
    check_eq("irq_wrap", {63'd0, timer_irq}, 64'd1);
    step(1, 0, MmioBase | 32'h4, 32'h0, 0);
    step(1, 0, MmioBase | 32'h8, 32'h0, 0);
    step(0, 1, MmioBase | 32'hC, 32'd10, 0);
    check_eq("snapshot_hi", {32'd0, mem_rdata}, 64'd0);
    idle();
    check_eq("irq_cmp10", {63'd0, timer_irq}, 64'd0);
    for (int i = 0; i < 10; i++) idle();
    check_eq("irq_reached", {63'd0, timer_irq}, 64'd1);
`else
    step(1, 0, MmioBase | 32'h4, 32'h0, 0);
    idle();
    check_eq("timer_off_err", {63'd0, bus_err}, 64'd1);
    check_eq("timer_off_irq", {63'd0, timer_irq}, 64'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
      else if (sel == 6) a = 32'h0000_4000;
      else if (sel == 7) a = MmioBase;
      else if (sel == 8) a = MmioBase | ($urandom_range(1, 5) << 2);
      else a = 32'h4000_0000 + $urandom_range(0, 255);
      r = bit'($urandom_range(0, 1));
      w = bit'($urandom_range(0, 1));
      if (w && region(a) == 2) w = 0;
      step(r, w, a, $urandom, 0);
    end

    // Reset while a read is in flight
    step(1, 0, 32'h10, 32'h0, 0);
    step(0, 0, 32'h0, 32'h0, 1);
    check_eq("rst_rvalid", {63'd0, mem_rvalid}, 64'd0);
    check_eq("rst_tohost", {32'd0, tohost}, 64'd0);
    check_eq("rst_irq", {63'd0, timer_irq}, 64'd0);
    step(1, 0, 32'h10, 32'h0, 0);
    idle();
    check_eq("ram_kept", {32'd0, mem_rdata}, {32'd0, m_ram[4]});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
